// File: rtl/router_read_arbiter_if.sv
// Bundle between the three FIFO read ports, the read arbiter and the output link.
// The master side is the arbiter; the slave side is the FIFOs plus the downstream sink.
interface router_read_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       fifo_empty;
  logic [WIDTH-1:0] fifo_dout_0;
  logic [WIDTH-1:0] fifo_dout_1;
  logic [WIDTH-1:0] fifo_dout_2;
  logic [2:0]       read_enb;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             grant_valid;
  logic [1:0]       grant;
  logic [2:0]       soft_reset;

  modport master (
    input  fifo_empty, fifo_dout_0, fifo_dout_1, fifo_dout_2, out_ready,
    output read_enb, data_out, data_valid, grant_valid, grant, soft_reset
  );

  modport slave (
    output fifo_empty, fifo_dout_0, fifo_dout_1, fifo_dout_2, out_ready,
    input  read_enb, data_out, data_valid, grant_valid, grant, soft_reset
  );
endinterface

// File: rtl/router_read_arbiter.sv
// Output-side scheduler of the 1x3 router. Grants the three destination FIFOs
// round-robin, one whole packet at a time (header, payload, parity), and aborts
// a granted packet with a one-cycle soft reset when the output link stalls too long.
module router_read_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 30,
  parameter int TCNT_W  = 8
) (
  input logic                   clk,
  input logic                   reset,
  router_read_arbiter_if.master bus
);

  // One extra bit so that a maximum-length header plus parity does not wrap.
  localparam int REM_W = WIDTH - 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       rr_ptr;
  logic [1:0]       grant_q;
  logic [REM_W-1:0] remaining;
  logic             hdr_seen;
  logic [TCNT_W-1:0] tcnt;
  logic [2:0]       soft_reset_q;

  logic [1:0]       cand0;
  logic [1:0]       cand1;
  logic [1:0]       pick;
  logic             pick_valid;
  logic [WIDTH-1:0] head_word;
  logic             head_empty;
  logic             transfer;
  logic             abort;
  logic [WIDTH-1:0] data_out_c;
  logic             data_valid_c;
  logic             grant_valid_c;
  logic [2:0]       read_enb_c;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic bit_at(input logic [2:0] vec, input logic [1:0] idx);
    case (idx)
      2'd0:    return vec[0];
      2'd1:    return vec[1];
      default: return vec[2];
    endcase
  endfunction

  // Pick the first non-empty FIFO after the last served one, wrapping back to it last.
  always_comb begin
    cand0      = next_idx(rr_ptr);
    cand1      = next_idx(cand0);
    pick_valid = ~&bus.fifo_empty;
    pick       = rr_ptr;
    if (!bit_at(bus.fifo_empty, cand0)) begin
      pick = cand0;
    end else if (!bit_at(bus.fifo_empty, cand1)) begin
      pick = cand1;
    end
  end

  // Select the head word and empty flag of the currently granted FIFO.
  always_comb begin
    case (grant_q)
      2'd0:    head_word = bus.fifo_dout_0;
      2'd1:    head_word = bus.fifo_dout_1;
      default: head_word = bus.fifo_dout_2;
    endcase
    head_empty = bit_at(bus.fifo_empty, grant_q);
  end

  // Next-state and output decode: only XFER drives the link, GAP lets fifo_empty settle.
  always_comb begin
    state_next    = state;
    data_out_c    = '0;
    data_valid_c  = 1'b0;
    grant_valid_c = 1'b0;
    read_enb_c    = 3'b000;
    transfer      = 1'b0;
    abort         = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = XFER;
        end
      end
      XFER: begin
        grant_valid_c = 1'b1;
        data_out_c    = head_word;
        data_valid_c  = !head_empty;
        transfer      = data_valid_c & bus.out_ready;
        if (transfer) begin
          read_enb_c = onehot(grant_q);
        end
        if (transfer && hdr_seen && (remaining == REM_W'(1))) begin
          state_next = GAP;
        end else if (!transfer && (tcnt == TCNT_LAST)) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Packet bookkeeping: grant, word countdown, stall timer, round-robin pointer, abort pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr       <= 2'd2;
      grant_q      <= 2'd0;
      remaining    <= '0;
      hdr_seen     <= 1'b0;
      tcnt         <= '0;
      soft_reset_q <= 3'b000;
    end else begin
      soft_reset_q <= 3'b000;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_q  <= pick;
            hdr_seen <= 1'b0;
            tcnt     <= '0;
          end
        end
        XFER: begin
          if (transfer) begin
            tcnt <= '0;
            if (!hdr_seen) begin
              hdr_seen  <= 1'b1;
              remaining <= REM_W'(head_word[WIDTH-1:2]) + REM_W'(1);
            end else begin
              remaining <= remaining - REM_W'(1);
            end
          end else if (abort) begin
            tcnt         <= '0;
            soft_reset_q <= onehot(grant_q);
            rr_ptr       <= grant_q;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        GAP: begin
          rr_ptr <= grant_q;
        end
        default: begin
          rr_ptr <= rr_ptr;
        end
      endcase
    end
  end

  assign bus.read_enb    = read_enb_c;
  assign bus.data_out    = data_out_c;
  assign bus.data_valid  = data_valid_c;
  assign bus.grant_valid = grant_valid_c;
  assign bus.grant       = grant_q;
  assign bus.soft_reset  = soft_reset_q;

endmodule

// File: tb/tb_router_read_arbiter.sv
// Bench for router_read_arbiter: three behavioural FIFOs feed the arbiter, stimulus
// loads packets and queues the words it expects to see on the link, and a negedge
// monitor pops and compares every transfer and every soft-reset pulse.
module tb_router_read_arbiter;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 30;

  logic clk;
  logic reset;

  router_read_arbiter_if #(.WIDTH(WIDTH)) bus ();

  router_read_arbiter #(
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT),
    .TCNT_W (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  fq0[$];
  logic [7:0]  fq1[$];
  logic [7:0]  fq2[$];
  logic [12:0] sb[$];
  logic [2:0]  sr_exp[$];
  logic [2:0]  pop_mask = 3'b000;
  logic [2:0]  sr_mask  = 3'b000;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] onehot(input int idx);
    case (idx)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic update_drives();
    bus.fifo_empty  = {fq2.size() == 0, fq1.size() == 0, fq0.size() == 0};
    bus.fifo_dout_0 = (fq0.size() != 0) ? fq0[0] : 8'h00;
    bus.fifo_dout_1 = (fq1.size() != 0) ? fq1[0] : 8'h00;
    bus.fifo_dout_2 = (fq2.size() != 0) ? fq2[0] : 8'h00;
  endtask

  task automatic push_word(input int f, input logic [7:0] w);
    case (f)
      0:       fq0.push_back(w);
      1:       fq1.push_back(w);
      default: fq2.push_back(w);
    endcase
  endtask

  // Load one packet into FIFO f; the first n_exp words are expected on the link in call order.
  task automatic apply_stimulus(input int f, input logic [7:0] hdr, input logic [7:0] base,
                                input logic [7:0] par, input int n_exp);
    int len;
    logic [7:0] w;
    len = int'(hdr[7:2]);
    for (int k = 0; k < len + 2; k++) begin
      if (k == 0) w = hdr;
      else if (k == len + 1) w = par;
      else w = base + 8'(k - 1);
      push_word(f, w);
      if (k < n_exp) sb.push_back({onehot(f), 2'(f), w});
    end
    update_drives();
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    #1;
    check_output(name, 32'({bus.grant_valid, bus.data_valid, bus.read_enb, bus.grant,
                            bus.soft_reset, bus.data_out}), 32'h0);
    fq0.delete();
    fq1.delete();
    fq2.delete();
    pop_mask = 3'b000;
    sr_mask  = 3'b000;
    update_drives();
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || fq0.size() != 0 || fq1.size() != 0 || fq2.size() != 0)
           && n < budget) begin
      cyc(1);
      n++;
    end
    check_output(name, 32'(n < budget), 32'h1);
    cyc(3);
  endtask

  // Monitor: every transfer and soft-reset pulse must match the next queued expectation.
  always @(negedge clk) begin
    logic [12:0] exp_x;
    logic [2:0]  exp_s;
    if (!reset) begin
      if (bus.read_enb != 3'b000) begin
        if (sb.size() == 0) begin
          check_output("unexpected_read", 32'({bus.read_enb, bus.grant, bus.data_out}), 32'h0);
        end else begin
          exp_x = sb.pop_front();
          check_output("xfer", 32'({bus.read_enb, bus.grant, bus.data_out}), 32'(exp_x));
        end
      end
      if (bus.soft_reset != 3'b000) begin
        if (sr_exp.size() == 0) begin
          check_output("unexpected_soft_reset", 32'(bus.soft_reset), 32'h0);
        end else begin
          exp_s = sr_exp.pop_front();
          check_output("soft_reset", 32'(bus.soft_reset), 32'(exp_s));
        end
      end
      pop_mask = bus.read_enb;
      sr_mask  = bus.soft_reset;
    end
  end

  // FIFO model: pops and soft-reset flushes take effect just after the clock edge.
  always @(posedge clk) begin
    #1;
    if (pop_mask[0] && fq0.size() != 0) void'(fq0.pop_front());
    if (pop_mask[1] && fq1.size() != 0) void'(fq1.pop_front());
    if (pop_mask[2] && fq2.size() != 0) void'(fq2.pop_front());
    if (sr_mask[0]) fq0.delete();
    if (sr_mask[1]) fq1.delete();
    if (sr_mask[2]) fq2.delete();
    pop_mask = 3'b000;
    sr_mask  = 3'b000;
    update_drives();
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete, %0d errors so far", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b1;
    update_drives();
    #1;
    check_output("reset_outputs", 32'({bus.grant_valid, bus.data_valid, bus.read_enb, bus.grant,
                                       bus.soft_reset, bus.data_out}), 32'h0);

    // Single FIFO1 packet, len 3.
    apply_stimulus(1, 8'h0D, 8'hA1, 8'hAD, 5);
    #1;
    check_output("reset_hold_outputs", 32'({bus.grant_valid, bus.read_enb, bus.data_valid}), 32'h0);
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    check_output("t1_idle_before_grant", 32'(bus.grant_valid), 32'h0);
    @(negedge clk);
    check_output("t1_grant_valid", 32'(bus.grant_valid), 32'h1);
    check_output("t1_grant", 32'(bus.grant), 32'h1);
    repeat (5) @(negedge clk);
    check_output("t1_gap_quiet", 32'({bus.grant_valid, bus.data_valid, bus.read_enb}), 32'h0);
    check_output("t1_gap_grant_hold", 32'(bus.grant), 32'h1);
    check_output("t1_all_words_read", 32'(sb.size()), 32'h0);
    @(negedge clk);
    check_output("t1_idle_after_gap", 32'(bus.grant_valid), 32'h0);
    cyc(1);

    // Three simultaneous len-1 packets from reset priority: 0, 1, 2.
    do_reset("t2_reset_outputs");
    apply_stimulus(0, 8'h04, 8'hB0, 8'hC0, 3);
    apply_stimulus(1, 8'h05, 8'hB1, 8'hC1, 3);
    apply_stimulus(2, 8'h06, 8'hB2, 8'hC2, 3);
    repeat (5) @(negedge clk);
    check_output("t2_gap_after_first", 32'(bus.grant_valid), 32'h0);
    @(negedge clk);
    check_output("t2_idle_after_first", 32'(bus.grant_valid), 32'h0);
    @(negedge clk);
    check_output("t2_second_grant", 32'({bus.grant_valid, bus.grant}), 32'h5);
    repeat (5) @(negedge clk);
    check_output("t2_third_grant", 32'({bus.grant_valid, bus.grant}), 32'h6);
    cyc(1);
    drain("t2_drain", 100);

    // FIFO0 holds two packets, FIFO2 one: FIFO2 must be served between them.
    apply_stimulus(0, 8'h04, 8'hD0, 8'hE0, 3);
    apply_stimulus(2, 8'h06, 8'hD2, 8'hE2, 3);
    apply_stimulus(0, 8'h08, 8'hD8, 8'hE8, 4);
    repeat (7) @(negedge clk);
    check_output("t3_fifo2_before_refill", 32'({bus.grant_valid, bus.grant}), 32'h6);
    cyc(1);
    drain("t3_drain", 100);

    // Zero-length header: header and parity only, then GAP.
    apply_stimulus(0, 8'h00, 8'h00, 8'h5A, 2);
    @(negedge clk);
    @(negedge clk);
    check_output("t4_grant", 32'({bus.grant_valid, bus.grant}), 32'h4);
    @(negedge clk);
    @(negedge clk);
    check_output("t4_gap_after_two", 32'({bus.grant_valid, bus.data_valid}), 32'h0);
    cyc(1);
    drain("t4_drain", 100);

    // FIFO2 stalls mid-payload; a transfer in the threshold cycle saves it, the second stall aborts.
    apply_stimulus(2, 8'h0E, 8'hF1, 8'hF0, 3);
    sr_exp.push_back(3'b100);
    cyc(3);
    bus.out_ready = 1'b0;
    cyc(29);
    bus.out_ready = 1'b1;
    cyc(1);
    bus.out_ready = 1'b0;
    cyc(7);
    apply_stimulus(0, 8'h00, 8'h00, 8'h33, 2);
    cyc(22);
    @(negedge clk);
    check_output("t5_no_abort_yet", 32'({bus.grant_valid, bus.soft_reset}), 32'h8);
    cyc(1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_output("t5_abort_pulse", 32'(bus.soft_reset), 32'h4);
    check_output("t5_abort_idle", 32'(bus.grant_valid), 32'h0);
    @(negedge clk);
    check_output("t5_pulse_once", 32'(bus.soft_reset), 32'h0);
    check_output("t5_next_grant", 32'({bus.grant_valid, bus.grant}), 32'h4);
    cyc(1);
    drain("t5_drain", 100);
    check_output("t5_abort_seen", 32'(sr_exp.size()), 32'h0);

    // Reset mid-packet: outputs clear at once and priority restarts from FIFO0.
    apply_stimulus(1, 8'h09, 8'hE1, 8'h77, 2);
    cyc(3);
    do_reset("t6_async_reset");
    apply_stimulus(0, 8'h04, 8'hE0, 8'h79, 3);
    apply_stimulus(1, 8'h09, 8'hE4, 8'h78, 4);
    @(negedge clk);
    @(negedge clk);
    check_output("t6_priority_restart", 32'({bus.grant_valid, bus.grant}), 32'h4);
    cyc(1);
    drain("t6_drain", 100);

    check_output("final_sb_empty", 32'(sb.size()), 32'h0);
    check_output("final_sr_empty", 32'(sr_exp.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
